node_feeder: RTL and testbench

- Producer side of the neuron accumulation path: for one neuron evaluation it walks N input/weight address pairs and reads both synchronous memories (1-cycle read latency).
- Multiplies each signed 12-bit input by a signed 8-bit weight and streams registered 20-bit signed products, framed with first/last flags, to the downstream accumulator.
- Sits between the layer controller (start/done) and the per-node accumulator.

---
 rtl/node_pkg.sv | 23 ++
 rtl/node_mul.sv | 28 ++
 rtl/node_feeder.sv | 167 ++++++++++++++++
 tb/tb_node_feeder.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/node_pkg.sv
// Shared definitions for the neuron feeder: widths, FSM encoding, bias
// sign-extension helper.
// Build option: NODE_FEEDER_BIAS_BEAT_EN (used by node_feeder).
package node_pkg;

   localparam int N_MAX = 1024;
   localparam int AW    = $clog2(N_MAX);
   localparam int XW    = 12;
   localparam int WW    = 8;
   localparam int PW    = XW + WW;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Widen a signed weight-sized value to activation width.
   function automatic logic [XW-1:0] sext_bias(input logic [WW-1:0] b);
      return {{(XW-WW){b[WW-1]}}, b};
   endfunction

endpackage

// File: rtl/node_mul.sv
// Registered signed XW x WW multiplier with a valid flag carried alongside.
// The product register only loads on valid, so it holds between beats.
module node_mul
   import node_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [XW-1:0] a,
   input  logic [WW-1:0] b,
   output logic [PW-1:0] p,
   output logic          out_valid
);

   // Full-width signed product, no truncation.
   always_ff @(posedge clk) begin
      if (!rst) begin
         p         <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            p <= $signed(a) * $signed(b);
         end
      end
   end

endmodule

// File: rtl/node_feeder.sv
// Neuron feeder: walks N input/weight address pairs, reads both synchronous
// memories and streams framed signed products to the accumulator.
// Build option: NODE_FEEDER_BIAS_BEAT_EN adds a leading sign-extended bias beat.
//
// Stream handshake: prod_valid qualifies prod, prod_first and prod_last;
// there is no ready, every beat is consumed in the cycle it is presented,
// and beats of one pass are contiguous.
//
// The FSM register `state` (state_t) is the observable state for checkers.
module node_feeder
   import node_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW:0]   num_in,
   input  logic [AW-1:0] x_base,
   input  logic [AW-1:0] w_base,
   output logic [AW-1:0] x_addr,
   output logic [AW-1:0] w_addr,
   output logic          mem_re,
   input  logic [XW-1:0] x_rdata,
   input  logic [WW-1:0] w_rdata,
   input  logic [WW-1:0] bias,
   output logic [PW-1:0] prod,
   output logic          prod_valid,
   output logic          prod_first,
   output logic          prod_last,
   output logic          busy,
   output logic          done
);

   state_t        state;
   logic [AW:0]   n_q;
   logic [AW:0]   idx;
   logic          rd_valid;
   logic          rd_last;
   logic          mul_valid;
   logic [XW-1:0] mul_a;
   logic [WW-1:0] mul_b;
   logic          first_in;

`ifdef NODE_FEEDER_BIAS_BEAT_EN
   logic [WW-1:0] bias_q;
   logic          bias_beat;
`else
   logic          rd_first;
   logic          unused_bias;
   assign unused_bias = ^bias;
`endif

   // Pass sequencing: accept start, issue N reads, wait for the last beat.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= ST_IDLE;
         n_q    <= '0;
         idx    <= '0;
         x_addr <= '0;
         w_addr <= '0;
         mem_re <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
`ifdef NODE_FEEDER_BIAS_BEAT_EN
         bias_q    <= '0;
         bias_beat <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
`ifdef NODE_FEEDER_BIAS_BEAT_EN
         bias_beat <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (num_in == '0) begin
                     // Empty pass: acknowledge immediately, no beats.
                     done <= 1'b1;
                  end else begin
                     n_q    <= num_in;
                     idx    <= '0;
                     x_addr <= x_base;
                     w_addr <= w_base;
                     mem_re <= 1'b1;
                     busy   <= 1'b1;
                     state  <= ST_ISSUE;
`ifdef NODE_FEEDER_BIAS_BEAT_EN
                     bias_q    <= bias;
                     bias_beat <= 1'b1;
`endif
                  end
               end
            end
            ST_ISSUE: begin
               if (idx == n_q - 1'b1) begin
                  mem_re <= 1'b0;
                  state  <= ST_DRAIN;
               end else begin
                  idx    <= idx + 1'b1;
                  x_addr <= x_addr + 1'b1;
                  w_addr <= w_addr + 1'b1;
               end
            end
            ST_DRAIN: begin
               if (prod_valid && prod_last) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Read stage: tag each returning memory word with its position in the pass.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
`ifndef NODE_FEEDER_BIAS_BEAT_EN
         rd_first <= 1'b0;
`endif
      end else begin
         rd_valid <= mem_re;
         rd_last  <= mem_re && (idx == n_q - 1'b1);
`ifndef NODE_FEEDER_BIAS_BEAT_EN
         rd_first <= mem_re && (idx == '0);
`endif
      end
   end

`ifdef NODE_FEEDER_BIAS_BEAT_EN
   // The bias beat reuses the multiplier as bias * 1, one cycle ahead of
   // the first memory word, so the stream stays gap-free.
   assign mul_valid = rd_valid | bias_beat;
   assign mul_a     = bias_beat ? sext_bias(bias_q) : x_rdata;
   assign mul_b     = bias_beat ? WW'(1) : w_rdata;
   assign first_in  = bias_beat;
`else
   assign mul_valid = rd_valid;
   assign mul_a     = x_rdata;
   assign mul_b     = w_rdata;
   assign first_in  = rd_first;
`endif

   node_mul u_mul (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (mul_valid),
      .a         (mul_a),
      .b         (mul_b),
      .p         (prod),
      .out_valid (prod_valid)
   );

   // Framing flags registered in step with the product register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         prod_first <= 1'b0;
         prod_last  <= 1'b0;
      end else begin
         prod_first <= first_in;
         prod_last  <= rd_last;
      end
   end

endmodule

// File: tb/tb_node_feeder.sv
// Bench for node_feeder: memory model, cycle-scheduled expectation model,
// per-cycle compare process, directed passes with literal checks.
module tb_node_feeder;
   import node_pkg::*;

`ifdef NODE_FEEDER_BIAS_BEAT_EN
   localparam int BIAS_EN = 1;
`else
   localparam int BIAS_EN = 0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW:0]   num_in;
   logic [AW-1:0] x_base;
   logic [AW-1:0] w_base;
   logic [AW-1:0] x_addr;
   logic [AW-1:0] w_addr;
   logic          mem_re;
   logic [XW-1:0] x_rdata = '0;
   logic [WW-1:0] w_rdata = '0;
   logic [WW-1:0] bias;
   logic [PW-1:0] prod;
   logic          prod_valid;
   logic          prod_first;
   logic          prod_last;
   logic          busy;
   logic          done;

   node_feeder dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .num_in     (num_in),
      .x_base     (x_base),
      .w_base     (w_base),
      .x_addr     (x_addr),
      .w_addr     (w_addr),
      .mem_re     (mem_re),
      .x_rdata    (x_rdata),
      .w_rdata    (w_rdata),
      .bias       (bias),
      .prod       (prod),
      .prod_valid (prod_valid),
      .prod_first (prod_first),
      .prod_last  (prod_last),
      .busy       (busy),
      .done       (done)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- memories (1-cycle synchronous read) ----------------
   int xm [N_MAX];
   int wm [N_MAX];

   always @(posedge clk) begin
      if (mem_re === 1'b1) begin
         x_rdata <= XW'(xm[x_addr]);
         w_rdata <= WW'(wm[w_addr]);
      end
   end

   // ---------------- scoreboard state ----------------
   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic [PW+1:0]   exp_q[$];      // {prod, first, last}
   int              exp_cyc_q[$];
   logic [2*AW-1:0] ea_q[$];       // {x_addr, w_addr}
   int              ea_cyc_q[$];
   int              done_q[$];
   int              busy_lo = 1;
   int              busy_hi = 0;
   logic [PW-1:0]   got_q[$];
   logic [AW-1:0]   xa_got_q[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, got, exp);
      end
   endtask

   // Model: from the pass parameters and memory contents, lay out every
   // output event of the pass on absolute cycle numbers.
   // Start seen in cycle s: reads in s+1..s+n, beats in s+3..s+n+2,
   // optional bias beat in s+2, done in s+n+3.
   function automatic void model_schedule(int s, int n, int xb, int wb, int b);
      int xa, wa, p;
      if (n == 0) begin
         done_q.push_back(s + 1);
         return;
      end
      if (BIAS_EN != 0) begin
         exp_q.push_back({PW'(b), 1'b1, 1'b0});
         exp_cyc_q.push_back(s + 2);
      end
      for (int i = 0; i < n; i++) begin
         xa = (xb + i) % N_MAX;
         wa = (wb + i) % N_MAX;
         p  = xm[xa] * wm[wa];
         exp_q.push_back({PW'(p), (i == 0) && (BIAS_EN == 0), i == n - 1});
         exp_cyc_q.push_back(s + 3 + i);
         ea_q.push_back({AW'(xa), AW'(wa)});
         ea_cyc_q.push_back(s + 1 + i);
      end
      done_q.push_back(s + n + 3);
      busy_lo = s + 1;
      busy_hi = s + n + 2;
   endfunction

   // Reset at the end of cycle r: nothing scheduled after r can happen.
   function automatic void model_abort(int r);
      while (exp_cyc_q.size() > 0 && exp_cyc_q[$] > r) begin
         void'(exp_cyc_q.pop_back());
         void'(exp_q.pop_back());
      end
      while (ea_cyc_q.size() > 0 && ea_cyc_q[$] > r) begin
         void'(ea_cyc_q.pop_back());
         void'(ea_q.pop_back());
      end
      done_q.delete();
      if (busy_hi > r) busy_hi = r;
   endfunction

   // ---------------- compare process ----------------
   logic [PW+1:0]   e;
   logic [2*AW-1:0] ea;
   bit              ev;

   always @(posedge clk) begin
      cyc++;
      #1;
      ev = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
      chk("prod_valid", 32'(prod_valid), 32'(ev));
      if (ev) begin
         e = exp_q.pop_front();
         void'(exp_cyc_q.pop_front());
         chk("prod", 32'(prod), 32'(e[PW+1:2]));
         chk("prod_first", 32'(prod_first), 32'(e[1]));
         chk("prod_last", 32'(prod_last), 32'(e[0]));
      end else begin
         chk("first_idle", 32'(prod_first), 32'd0);
         chk("last_idle", 32'(prod_last), 32'd0);
      end
      if (prod_valid === 1'b1) got_q.push_back(prod);

      ev = (ea_cyc_q.size() > 0) && (ea_cyc_q[0] == cyc);
      chk("mem_re", 32'(mem_re), 32'(ev));
      if (ev) begin
         ea = ea_q.pop_front();
         void'(ea_cyc_q.pop_front());
         chk("x_addr", 32'(x_addr), 32'(ea[2*AW-1:AW]));
         chk("w_addr", 32'(w_addr), 32'(ea[AW-1:0]));
      end
      if (mem_re === 1'b1) xa_got_q.push_back(x_addr);

      ev = (done_q.size() > 0) && (done_q[0] == cyc);
      chk("done", 32'(done), 32'(ev));
      if (ev) void'(done_q.pop_front());

      chk("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
   end

   // ---------------- driver tasks ----------------
   // Called right after a negedge; returns one negedge later.
   task automatic start_pass(input int n, input int xb, input int wb, input int b, output int s);
      num_in = (AW+1)'(n);
      x_base = AW'(xb);
      w_base = AW'(wb);
      bias   = WW'(b);
      start  = 1'b1;
      s      = cyc;
      model_schedule(s, n, xb, wb, b);
      @(negedge clk);
      start  = 1'b0;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic chk_beat(input string name, input int idx, input int val);
      logic [PW-1:0] t;
      t = PW'(val);
      if (idx >= got_q.size()) chk(name, 32'hdead_beef, 32'(t));
      else chk(name, 32'(got_q[idx]), 32'(t));
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   int s, s2, k;

   initial begin
      rst    = 1'b0;
      start  = 1'b0;
      num_in = '0;
      x_base = '0;
      w_base = '0;
      bias   = '0;

      repeat (3) @(negedge clk);
      chk("rst_prod", 32'(prod), 32'd0);
      chk("rst_valid", 32'(prod_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_mem_re", 32'(mem_re), 32'd0);
      chk("rst_x_addr", 32'(x_addr), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // T1: N=4, basic products
      xm[0] = 1; xm[1] = 2; xm[2] = 3; xm[3] = 4;
      wm[0] = 5; wm[1] = -1; wm[2] = 2; wm[3] = 0;
      got_q.delete();
      start_pass(4, 0, 0, 0, s);
      wait_until(s + 4 + 3);
      chk("t1_count", 32'(got_q.size()), 32'(4 + BIAS_EN));
      chk_beat("t1_b0", BIAS_EN + 0, 5);
      chk_beat("t1_b1", BIAS_EN + 1, -2);
      chk_beat("t1_b2", BIAS_EN + 2, 6);
      chk_beat("t1_b3", BIAS_EN + 3, 0);

      // T2: N=1, extreme negative operands
      xm[10] = -2048; wm[20] = -128;
      got_q.delete();
      start_pass(1, 10, 20, 5, s);
      wait_until(s + 1 + 3);
      chk("t2_count", 32'(got_q.size()), 32'(1 + BIAS_EN));
      chk_beat("t2_prod", BIAS_EN, 262144);

      // T3: address wrap
      xm[1022] = 3; xm[1023] = -7; xm[0] = 1; xm[1] = 2;
      wm[5] = 11; wm[6] = 13; wm[7] = -1; wm[8] = 127;
      xa_got_q.delete();
      got_q.delete();
      start_pass(4, 1022, 5, -9, s);
      wait_until(s + 4 + 3);
      chk("t3_acount", 32'(xa_got_q.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         k = (i < 2) ? 1022 + i : i - 2;
         if (i < xa_got_q.size()) chk("t3_xaddr", 32'(xa_got_q[i]), 32'(k));
      end
      chk_beat("t3_b1", BIAS_EN + 1, -91);

      // T4: start ignored mid-pass, then start on the done cycle
      for (int i = 0; i < 6; i++) begin
         xm[40 + i] = i - 3;
         wm[60 + i] = 2 * i + 1;
      end
      got_q.delete();
      start_pass(6, 40, 60, 1, s);
      wait_until(s + 3);
      num_in = (AW+1)'(2);
      x_base = AW'(100);
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      wait_until(s + 6 + 3);
      chk("t4_count", 32'(got_q.size()), 32'(6 + BIAS_EN));
      start_pass(3, 40, 60, 2, s2);
      chk("t4_b2b_start", 32'(s2), 32'(s + 9));
      wait_until(s2 + 3 + 3);
      chk("t4_count2", 32'(got_q.size()), 32'(9 + 2 * BIAS_EN));

      // T5: reset during beat 2 of N=8
      for (int i = 0; i < 8; i++) begin
         xm[400 + i] = i + 1;
         wm[500 + i] = -2;
      end
      got_q.delete();
      start_pass(8, 400, 500, 4, s);
      wait_until(s + 5);
      rst = 1'b0;
      model_abort(cyc);
      @(negedge clk);
      chk("t5_prod_rst", 32'(prod), 32'd0);
      chk("t5_busy_rst", 32'(busy), 32'd0);
      rst = 1'b1;
      repeat (14) @(negedge clk);
      chk("t5_count", 32'(got_q.size()), 32'(3));

      // T6: num_in = 0 is a no-op with a done pulse
      got_q.delete();
      start_pass(0, 0, 0, 0, s);
      wait_until(s + 4);
      chk("t6_count", 32'(got_q.size()), 32'd0);

      // T7: bias -3, N=2
      xm[200] = 7; xm[201] = -5;
      wm[300] = 3; wm[301] = 4;
      got_q.delete();
      start_pass(2, 200, 300, -3, s);
      wait_until(s + 2 + 3);
      chk("t7_count", 32'(got_q.size()), 32'(2 + BIAS_EN));
      if (BIAS_EN != 0) chk_beat("t7_bias", 0, -3);
      chk_beat("t7_p0", BIAS_EN + 0, 21);
      chk_beat("t7_p1", BIAS_EN + 1, -20);

      repeat (4) @(negedge clk);
      chk("end_exp_empty", 32'(exp_q.size() + done_q.size() + ea_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
